// File: rtl/usb_txn_ctrl.sv
// rtl/usb_txn_ctrl.sv - USB full-speed endpoint transaction sequencer
// Purpose: answers OUT/IN host tokens with ACK/NAK/DATAx after a bus turnaround
//          and tracks the shared data-toggle bit.
// Ports:   clk, n_rst (synchronous, active-high reset)
//          rx_packet/rx_data_ready/rx_transfer_active/rx_error  from usb_rx
//          tx_packet (request), tx_transfer_active/tx_error      to/from usb_tx
//          buffer_occupancy/clear                                FIFO status/flush
//          tx_arm                                                software IN-ready level
//          data_toggle, out_done, in_done, in_timeout, busy      status (all registered)
module usb_txn_ctrl #(
    parameter int unsigned TURNAROUND  = 8,
    parameter logic [15:0] ACK_TIMEOUT = 16'd1000,
    parameter logic [6:0]  BUF_LIMIT   = 7'd64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [3:0] rx_packet,
    input  logic       rx_data_ready,
    input  logic       rx_transfer_active,
    input  logic       rx_error,
    input  logic       tx_transfer_active,
    input  logic       tx_error,
    input  logic [6:0] buffer_occupancy,
    input  logic       tx_arm,
    output logic [3:0] tx_packet,
    output logic       clear,
    output logic       data_toggle,
    output logic       out_done,
    output logic       in_done,
    output logic       in_timeout,
    output logic       busy
);

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;

    localparam logic [3:0] TA_LOAD     = 4'(TURNAROUND - 1);
    localparam logic [7:0] TX_WAIT_MAX = 8'd254;  // 255th low cycle gives up

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_DATA, S_TA, S_SEND, S_TX_START, S_TX_END, S_WAIT_ACK
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  pid_q, pid_d;          // pending PID to send after turnaround
    logic        dup_q, dup_d;          // OUT data was a retransmitted duplicate
    logic [3:0]  ta_cnt_q, ta_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] timer_q, timer_d;

    logic [3:0]  tx_packet_q, tx_packet_d;
    logic        clear_q, clear_d;
    logic        toggle_q, toggle_d;
    logic        out_done_q, out_done_d;
    logic        in_done_q, in_done_d;
    logic        in_timeout_q, in_timeout_d;
    logic        busy_q, busy_d;

    // Packet boundaries come from rx_data_ready/rx_error; the activity level adds nothing.
    logic unused_rx_active;
    assign unused_rx_active = rx_transfer_active;

    // A corrupt packet overrides its own ready pulse.
    logic rx_valid, rx_is_data, rx_toggle, sent_data, tx_give_up;
    assign rx_valid   = rx_data_ready & ~rx_error;
    assign rx_is_data = (rx_packet == PID_DATA0) || (rx_packet == PID_DATA1);
    assign rx_toggle  = (rx_packet == PID_DATA1);
    assign sent_data  = (pid_q == PID_DATA0) || (pid_q == PID_DATA1);
    assign tx_give_up = ~tx_transfer_active && (wait_cnt_q == TX_WAIT_MAX);

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q      <= S_IDLE;
            pid_q        <= 4'h0;
            dup_q        <= 1'b0;
            ta_cnt_q     <= 4'h0;
            wait_cnt_q   <= 8'h0;
            timer_q      <= 16'h0;
            tx_packet_q  <= 4'h0;
            clear_q      <= 1'b0;
            toggle_q     <= 1'b0;
            out_done_q   <= 1'b0;
            in_done_q    <= 1'b0;
            in_timeout_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pid_q        <= pid_d;
            dup_q        <= dup_d;
            ta_cnt_q     <= ta_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            timer_q      <= timer_d;
            tx_packet_q  <= tx_packet_d;
            clear_q      <= clear_d;
            toggle_q     <= toggle_d;
            out_done_q   <= out_done_d;
            in_done_q    <= in_done_d;
            in_timeout_q <= in_timeout_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pid_d      = pid_q;
        dup_d      = dup_q;
        ta_cnt_d   = ta_cnt_q;
        wait_cnt_d = wait_cnt_q;
        timer_d    = timer_q;
        unique case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_packet == PID_OUT) begin
                    state_d = S_WAIT_DATA;
                end else if (rx_valid && rx_packet == PID_IN) begin
                    state_d  = S_TA;
                    ta_cnt_d = TA_LOAD;
                    dup_d    = 1'b0;
                    if (tx_arm && buffer_occupancy != 7'd0)
                        pid_d = toggle_q ? PID_DATA1 : PID_DATA0;
                    else
                        pid_d = PID_NAK;
                end
            end
            S_WAIT_DATA: begin
                if (rx_error) begin
                    state_d = S_IDLE;
                end else if (rx_data_ready) begin
                    if (rx_is_data) begin
                        state_d  = S_TA;
                        ta_cnt_d = TA_LOAD;
                        dup_d    = (rx_toggle != toggle_q);
                        // A duplicate is re-ACKed so the host can advance its toggle.
                        if (rx_toggle != toggle_q || buffer_occupancy < BUF_LIMIT)
                            pid_d = PID_ACK;
                        else
                            pid_d = PID_NAK;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_TA: begin
                if (ta_cnt_q == 4'h0) state_d = S_SEND;
                else                  ta_cnt_d = ta_cnt_q - 4'h1;
            end
            S_SEND: begin
                state_d    = S_TX_START;
                wait_cnt_d = 8'h0;
            end
            S_TX_START: begin
                if (tx_error || tx_give_up)  state_d = S_IDLE;
                else if (tx_transfer_active) state_d = S_TX_END;
                else                         wait_cnt_d = wait_cnt_q + 8'h1;
            end
            S_TX_END: begin
                if (tx_error) begin
                    state_d = S_IDLE;
                end else if (!tx_transfer_active) begin
                    if (sent_data) begin
                        state_d = S_WAIT_ACK;
                        timer_d = ACK_TIMEOUT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT_ACK: begin
                // Timer reaching 1 marks the ACK_TIMEOUT-th cycle in this state.
                if (rx_error || rx_data_ready || timer_q <= 16'd1) state_d = S_IDLE;
                else                                               timer_d = timer_q - 16'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_packet_d  = 4'h0;
        clear_d      = 1'b0;
        toggle_d     = toggle_q;
        out_done_d   = 1'b0;
        in_done_d    = 1'b0;
        in_timeout_d = 1'b0;
        busy_d       = (state_d != S_IDLE);
        unique case (state_q)
            S_WAIT_DATA: begin
                if (rx_error)
                    clear_d = 1'b1;
                else if (rx_data_ready && (!rx_is_data || rx_toggle != toggle_q))
                    clear_d = 1'b1;
            end
            S_SEND: tx_packet_d = pid_q;
            S_TX_START: begin
                if (tx_error || tx_give_up) in_timeout_d = sent_data;
            end
            S_TX_END: begin
                if (tx_error) begin
                    in_timeout_d = sent_data;
                end else if (!tx_transfer_active && pid_q == PID_ACK && !dup_q) begin
                    toggle_d   = ~toggle_q;
                    out_done_d = 1'b1;
                end
            end
            S_WAIT_ACK: begin
                if (rx_valid && rx_packet == PID_ACK) begin
                    toggle_d  = ~toggle_q;
                    in_done_d = 1'b1;
                end else if (rx_error || rx_data_ready || timer_q <= 16'd1) begin
                    in_timeout_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign tx_packet   = tx_packet_q;
    assign clear       = clear_q;
    assign data_toggle = toggle_q;
    assign out_done    = out_done_q;
    assign in_done     = in_done_q;
    assign in_timeout  = in_timeout_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// tb/tb_usb_txn_ctrl.sv - self-checking bench for usb_txn_ctrl
module tb_usb_txn_ctrl;
    localparam int N      = 4096;
    localparam int TURN   = 8;
    localparam int ACK_TO = 1000;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic [3:0] rx_packet = 4'h0;
    logic       rx_data_ready = 1'b0;
    logic       rx_transfer_active = 1'b0;
    logic       rx_error = 1'b0;
    logic       tx_transfer_active = 1'b0;
    logic       tx_error = 1'b0;
    logic [6:0] buffer_occupancy = 7'd0;
    logic       tx_arm = 1'b0;
    logic [3:0] tx_packet;
    logic       clear, data_toggle, out_done, in_done, in_timeout, busy;

    always #5 clk = ~clk;

    usb_txn_ctrl #(.TURNAROUND(TURN), .ACK_TIMEOUT(16'd1000), .BUF_LIMIT(7'd64)) dut (
        .clk(clk), .n_rst(n_rst), .rx_packet(rx_packet), .rx_data_ready(rx_data_ready),
        .rx_transfer_active(rx_transfer_active), .rx_error(rx_error),
        .tx_transfer_active(tx_transfer_active), .tx_error(tx_error),
        .buffer_occupancy(buffer_occupancy), .tx_arm(tx_arm), .tx_packet(tx_packet),
        .clear(clear), .data_toggle(data_toggle), .out_done(out_done), .in_done(in_done),
        .in_timeout(in_timeout), .busy(busy)
    );

    // cyc = number of the last rising edge; outputs registered at edge k belong to index k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit [3:0] exp_txp [N];
    bit       exp_clear [N];
    bit       exp_od [N];
    bit       exp_id [N];
    bit       exp_to [N];
    bit       exp_busy [N];
    bit       exp_tog [N];
    bit       m_tog = 1'b0;
    int       checks = 0;
    int       failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < N) begin
            chk("tx_packet",   tx_packet,   exp_txp[cyc]);
            chk("clear",       clear,       exp_clear[cyc]);
            chk("out_done",    out_done,    exp_od[cyc]);
            chk("in_done",     in_done,     exp_id[cyc]);
            chk("in_timeout",  in_timeout,  exp_to[cyc]);
            chk("busy",        busy,        exp_busy[cyc]);
            chk("data_toggle", data_toggle, exp_tog[cyc]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic fill_busy(input int a, input int b);
        for (int i = a; i < b && i < N; i++) exp_busy[i] = 1'b1;
    endtask

    task automatic fill_tog(input int a, input bit v);
        for (int i = a; i < N; i++) exp_tog[i] = v;
    endtask

    // The pulse is sampled at edge cyc+1.
    task automatic pulse_rx(input logic [3:0] pid, input bit err);
        rx_packet = pid; rx_data_ready = 1'b1; rx_error = err;
        step();
        rx_packet = 4'h0; rx_data_ready = 1'b0; rx_error = 1'b0;
    endtask

    // tx_transfer_active is seen high from edge 'rise' and low again at edge 'fall'.
    task automatic drive_tx(input int rise, input int fall);
        wait_until(rise - 1); tx_transfer_active = 1'b1;
        wait_until(fall - 1); tx_transfer_active = 1'b0;
    endtask

    task automatic do_out(input logic [3:0] data_pid, input int occ,
                          input int lit_pid, input int lit_tog);
        int t, d, s, f;
        bit match;
        bit [3:0] pid;
        t = cyc + 1; d = t + 4; s = d + TURN + 1; f = s + 7;
        match = ((data_pid == 4'hB) == m_tog);
        pid = !match ? 4'h2 : (occ < 64 ? 4'h2 : 4'hA);
        exp_txp[s] = pid;
        if (!match) exp_clear[d] = 1'b1;
        if (pid == 4'h2 && match) begin
            exp_od[f] = 1'b1; m_tog = ~m_tog; fill_tog(f, m_tog);
        end
        fill_busy(t, f);
        buffer_occupancy = 7'(occ);
        pulse_rx(4'h1, 1'b0);
        wait_until(d - 1); pulse_rx(data_pid, 1'b0);
        wait_until(s); chk("lit_out_pid", tx_packet, lit_pid);
        drive_tx(s + 2, f);
        wait_until(f + 3);
        chk("lit_out_tog", data_toggle, lit_tog);
    endtask

    // OUT token followed by a bad/non-DATA packet: flush and back to idle.
    task automatic do_out_abort(input logic [3:0] pid, input bit err);
        int t, d;
        t = cyc + 1; d = t + 4;
        exp_clear[d] = 1'b1;
        fill_busy(t, d);
        pulse_rx(4'h1, 1'b0);
        wait_until(d - 1); pulse_rx(pid, err);
        chk("lit_abort_clear", clear, 1);
        wait_until(d + 3);
    endtask

    // ack_delay < 0: no ACK; rst_at >= 0: reset that many cycles into WAIT_ACK.
    task automatic do_in(input bit arm, input int occ, input int ack_delay,
                         input int rst_at, input int lit_pid);
        int t, s, f, e;
        bit [3:0] pid;
        t = cyc + 1; s = t + TURN + 1; f = s + 7;
        pid = (arm && occ != 0) ? (m_tog ? 4'hB : 4'h3) : 4'hA;
        exp_txp[s] = pid;
        if (pid == 4'hA) begin
            e = f;
        end else if (rst_at >= 0) begin
            e = f + rst_at; m_tog = 1'b0; fill_tog(e, 1'b0);
        end else if (ack_delay >= 0) begin
            e = f + ack_delay; exp_id[e] = 1'b1; m_tog = ~m_tog; fill_tog(e, m_tog);
        end else begin
            e = f + ACK_TO; exp_to[e] = 1'b1;
        end
        fill_busy(t, e);
        tx_arm = arm; buffer_occupancy = 7'(occ);
        pulse_rx(4'h9, 1'b0);
        wait_until(s); chk("lit_in_pid", tx_packet, lit_pid);
        drive_tx(s + 2, f);
        if (pid != 4'hA) begin
            if (rst_at >= 0) begin
                wait_until(e - 1); n_rst = 1'b1; step(); n_rst = 1'b0;
                chk("lit_rst_tog", data_toggle, 0);
                chk("lit_rst_busy", busy, 0);
            end else if (ack_delay >= 0) begin
                wait_until(e - 1); pulse_rx(4'h2, 1'b0);
                chk("lit_in_done", in_done, 1);
            end else begin
                wait_until(e - 1); chk("lit_to_early", in_timeout, 0);
                step(); chk("lit_to_exact", in_timeout, 1);
            end
        end
        wait_until(e + 3);
    endtask

    initial begin
        step(); step(); step();
        n_rst = 1'b0;
        chk("lit_reset_busy", busy, 0);
        step();
        pulse_rx(4'h2, 1'b0);                  // stray ACK in IDLE is ignored
        wait_until(cyc + 3);
        do_out(4'h3, 10, 4'h2, 1);             // normal OUT DATA0
        do_out(4'h3, 10, 4'h2, 1);             // duplicate DATA0
        do_out(4'hB, 64, 4'hA, 1);             // buffer full -> NAK
        do_out(4'hB, 63, 4'h2, 0);             // just below limit -> ACK
        do_in(1'b1, 8, 40, -1, 4'h3);          // DATA0, host ACK after 40
        do_in(1'b1, 8, -1, -1, 4'hB);          // DATA1, no ACK -> timeout
        do_in(1'b0, 8, -1, -1, 4'hA);          // not armed -> NAK
        do_in(1'b1, 0, -1, -1, 4'hA);          // empty buffer -> NAK
        do_in(1'b1, 8, -1, 20, 4'hB);          // reset during WAIT_ACK
        do_in(1'b1, 8, 5, -1, 4'h3);           // after reset: DATA0
        do_out_abort(4'hB, 1'b1);              // DATA with rx_error
        do_out_abort(4'h9, 1'b0);              // non-DATA PID after OUT
        do_in(1'b1, 8, ACK_TO, -1, 4'hB);      // ACK on the timeout cycle wins
        chk("lit_final_tog", data_toggle, 0);
        wait_until(cyc + 5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
